// File: rtl/save_pkg.sv
// Shared types and path-layout constants for the SRAM save sequencer.
package save_pkg;

   typedef enum logic [3:0] {
      IDLE,
      COPY,
      TERM,
      OPEN_ACK,
      OPEN_DONE,
      WRITE_ACK,
      WRITE_DONE,
      FINISH,
      FAIL
   } save_state_t;

   localparam int unsigned PATH_PREFIX_LENGTH = 26;
   localparam int unsigned PATH_INDEX_DIGITS  = 2;
   localparam int unsigned PATH_SUFFIX_LENGTH = 4;

endpackage

// File: rtl/save_file_sequencer.sv
// Sequences one SRAM save: copy the save-file path into the bridge filename
// buffer, then issue dataslot openfile and dataslot write commands.
module save_file_sequencer
   import save_pkg::*;
#(
   parameter int unsigned PATH_LENGTH    = PATH_PREFIX_LENGTH + PATH_INDEX_DIGITS + PATH_SUFFIX_LENGTH,
   parameter int unsigned MAX_INDEX      = 99,
   parameter logic [15:0] SLOT_ID        = 16'h0000,
   parameter logic [31:0] SAVE_LENGTH    = 32'h20000,
   parameter int unsigned TIMEOUT_CYCLES = 2**24
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        save_req,
   output logic        busy,
   output logic        save_done,
   output logic        save_error,
   output logic [6:0]  save_index,
   output logic [7:0]  path_addr,
   input  logic [7:0]  path_q,
   output logic        buf_wr,
   output logic [7:0]  buf_addr,
   output logic [7:0]  buf_data,
   output logic        target_dataslot_openfile,
   output logic        target_dataslot_write,
   output logic [15:0] target_dataslot_id,
   output logic [31:0] target_dataslot_length,
   input  logic        target_dataslot_ack,
   input  logic        target_dataslot_done,
   input  logic [2:0]  target_dataslot_err
);

   localparam int unsigned CW = $clog2(PATH_LENGTH + 1);
   localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   save_state_t   state, next_state;
   logic [CW-1:0] copy_cnt;
   logic [TW-1:0] timer;
   logic          wait_state;
   logic          copy_last;
   logic          timed_out;
   logic          err_ok;

   assign wait_state = (state inside {OPEN_ACK, OPEN_DONE, WRITE_ACK, WRITE_DONE});
   assign copy_last  = (copy_cnt == CW'(PATH_LENGTH));
   assign timed_out  = (timer == TW'(TIMEOUT_CYCLES - 1));
   assign err_ok     = (target_dataslot_err == 3'd0);

   // copy_cnt runs one past the last path byte so the final read-data byte
   // can still be written in COPY; the terminator then goes out in TERM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         copy_cnt   <= '0;
         timer      <= '0;
         save_index <= '0;
      end else begin
         state <= next_state;
         if (state == COPY)
            copy_cnt <= copy_cnt + 1'b1;
         else
            copy_cnt <= '0;
         if (next_state != state)
            timer <= '0;
         else if (wait_state)
            timer <= timer + 1'b1;
         if (state == FINISH)
            save_index <= (save_index == 7'(MAX_INDEX)) ? '0 : 7'(save_index + 7'd1);
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:       if (save_req) next_state = COPY;
         COPY:       if (copy_last) next_state = TERM;
         TERM:       next_state = OPEN_ACK;
         OPEN_ACK: begin
            if (target_dataslot_ack) begin
               if (target_dataslot_done)
                  next_state = err_ok ? WRITE_ACK : FAIL;
               else
                  next_state = OPEN_DONE;
            end else if (timed_out) begin
               next_state = FAIL;
            end
         end
         OPEN_DONE: begin
            if (target_dataslot_done)
               next_state = err_ok ? WRITE_ACK : FAIL;
            else if (timed_out)
               next_state = FAIL;
         end
         WRITE_ACK: begin
            if (target_dataslot_ack) begin
               if (target_dataslot_done)
                  next_state = err_ok ? FINISH : FAIL;
               else
                  next_state = WRITE_DONE;
            end else if (timed_out) begin
               next_state = FAIL;
            end
         end
         WRITE_DONE: begin
            if (target_dataslot_done)
               next_state = err_ok ? FINISH : FAIL;
            else if (timed_out)
               next_state = FAIL;
         end
         FINISH:     next_state = IDLE;
         FAIL:       next_state = IDLE;
         default:    next_state = IDLE;
      endcase
   end

   always_comb begin
      busy                     = 1'b0;
      save_done                = 1'b0;
      save_error               = 1'b0;
      path_addr                = '0;
      buf_wr                   = 1'b0;
      buf_addr                 = '0;
      buf_data                 = '0;
      target_dataslot_openfile = 1'b0;
      target_dataslot_write    = 1'b0;
      target_dataslot_id       = '0;
      target_dataslot_length   = '0;
      case (state)
         COPY: begin
            busy      = 1'b1;
            path_addr = (copy_cnt < CW'(PATH_LENGTH)) ? 8'(copy_cnt) : 8'(PATH_LENGTH - 1);
            buf_wr    = (copy_cnt != '0);
            buf_addr  = 8'(copy_cnt - 1'b1);
            buf_data  = path_q;
         end
         TERM: begin
            busy     = 1'b1;
            buf_wr   = 1'b1;
            buf_addr = 8'(PATH_LENGTH);
            buf_data = 8'h00;
         end
         OPEN_ACK: begin
            busy                     = 1'b1;
            target_dataslot_openfile = 1'b1;
            target_dataslot_id       = SLOT_ID;
         end
         OPEN_DONE: begin
            busy               = 1'b1;
            target_dataslot_id = SLOT_ID;
         end
         WRITE_ACK: begin
            busy                   = 1'b1;
            target_dataslot_write  = 1'b1;
            target_dataslot_id     = SLOT_ID;
            target_dataslot_length = SAVE_LENGTH;
         end
         WRITE_DONE: begin
            busy                   = 1'b1;
            target_dataslot_id     = SLOT_ID;
            target_dataslot_length = SAVE_LENGTH;
         end
         FINISH:  save_done  = 1'b1;
         FAIL:    save_error = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_save_file_sequencer.sv
// Bench for save_file_sequencer: write_path and bridge models with directed
// and randomized saves checked against a path/index/latency reference model.
module tb_save_file_sequencer;

   localparam int unsigned TMO  = 16;
   localparam logic [15:0] SLOT = 16'h00A5;
   localparam logic [31:0] LEN  = 32'h20000;

   logic        clk = 1'b0;
   logic        rst;
   logic        save_req;
   logic        busy, save_done, save_error;
   logic [6:0]  save_index;
   logic [7:0]  path_addr, path_q, buf_addr, buf_data;
   logic        buf_wr, openfile, write_cmd;
   logic [15:0] ds_id;
   logic [31:0] ds_len;
   logic        ack, done;
   logic [2:0]  err;

   save_file_sequencer #(
      .MAX_INDEX      (99),
      .SLOT_ID        (SLOT),
      .SAVE_LENGTH    (LEN),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk                      (clk),
      .reset                    (rst),
      .save_req                 (save_req),
      .busy                     (busy),
      .save_done                (save_done),
      .save_error               (save_error),
      .save_index               (save_index),
      .path_addr                (path_addr),
      .path_q                   (path_q),
      .buf_wr                   (buf_wr),
      .buf_addr                 (buf_addr),
      .buf_data                 (buf_data),
      .target_dataslot_openfile (openfile),
      .target_dataslot_write    (write_cmd),
      .target_dataslot_id       (ds_id),
      .target_dataslot_length   (ds_len),
      .target_dataslot_ack      (ack),
      .target_dataslot_done     (done),
      .target_dataslot_err      (err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] path_char(input int unsigned a, input int unsigned idx);
      string pre = "/Saves/camera/common/SRAM_";
      string suf = ".sav";
      if (a < 26) return pre[a];
      if (a == 26) return 8'(48 + idx / 10);
      if (a == 27) return 8'(48 + idx % 10);
      if (a < 32) return suf[a - 28];
      return 8'h00;
   endfunction

   // write_path: synchronous ROM, data one cycle after address
   always @(posedge clk) path_q <= path_char(int'(path_addr), int'(save_index));

   // bridge: ack cfg_ack_dly cycles into a request, done cfg_done_dly cycles after ack
   int unsigned cfg_ack_dly = 0, cfg_done_dly = 0;
   logic [2:0]  cfg_open_err = 0, cfg_write_err = 0;
   bit          cfg_never_ack = 0;
   int unsigned req_cnt = 0, done_cnt = 0;
   bit          awaiting = 0;
   logic [2:0]  cur_err = 0;

   always @(negedge clk) begin
      ack = 1'b0; done = 1'b0; err = 3'd0;
      if (rst) begin
         req_cnt = 0; awaiting = 0;
      end else if (awaiting) begin
         if (done_cnt == 0) begin done = 1'b1; err = cur_err; awaiting = 0; end
         else done_cnt--;
      end else if ((openfile || write_cmd) && !cfg_never_ack) begin
         if (req_cnt == cfg_ack_dly) begin
            ack = 1'b1; req_cnt = 0;
            cur_err = openfile ? cfg_open_err : cfg_write_err;
            if (cfg_done_dly == 0) begin done = 1'b1; err = cur_err; end
            else begin awaiting = 1; done_cnt = cfg_done_dly - 1; end
         end else req_cnt++;
      end else req_cnt = 0;
   end

   int n_assert = 0, n_fail = 0;
   int unsigned exp_idx = 0;
   logic [7:0] buf_mem [0:63];
   int busy_cycles, open_cyc, write_seen, wr_count, addr_err, proto_err, rises, next_addr;
   bit got_done, got_err, finished;
   logic [7:0] fp_addr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at a negedge one cycle after the end pulse.
   task automatic run_save(input int extra_req_at);
      bit prev_busy = 0;
      busy_cycles = 0; open_cyc = 0; write_seen = 0; wr_count = 0; addr_err = 0;
      proto_err = 0; rises = 0; next_addr = 0; got_done = 0; got_err = 0; finished = 0;
      for (int i = 0; i < 64; i++) buf_mem[i] = 8'hEE;
      save_req = 1'b1;
      @(negedge clk);
      save_req = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if (c == 0) fp_addr = path_addr;
         if (busy) busy_cycles++;
         if (busy && !prev_busy) rises++;
         prev_busy = busy;
         if (buf_wr) begin
            if (int'(buf_addr) != next_addr) addr_err++;
            buf_mem[buf_addr[5:0]] = buf_data;
            next_addr++; wr_count++;
         end
         if (openfile) begin open_cyc++; if (ds_id !== SLOT) proto_err++; end
         if (write_cmd) begin write_seen++; if (ds_id !== SLOT || ds_len !== LEN) proto_err++; end
         if (openfile && write_cmd) proto_err++;
         if (save_done) got_done = 1;
         if (save_error) got_err = 1;
         save_req = (c == extra_req_at);
         if (got_done || got_err) begin finished = 1; break; end
         @(negedge clk);
      end
      save_req = 1'b0;
      check("bounded_wait", 32'(finished), 32'd1);
      @(negedge clk);
   endtask

   task automatic do_save(input int unsigned a, input int unsigned d,
                          input logic [2:0] oe, input logic [2:0] we);
      int unsigned idx0 = exp_idx;
      bit exp_ok = (oe == 0) && (we == 0);
      int unsigned exp_busy = 34 + (a + 1 + d) * ((oe == 0) ? 2 : 1);
      int mism = 0;
      cfg_ack_dly = a; cfg_done_dly = d; cfg_open_err = oe; cfg_write_err = we;
      run_save(-1);
      for (int i = 0; i < 32; i++) if (buf_mem[i] !== path_char(i, idx0)) mism++;
      if (buf_mem[32] !== 8'h00) mism++;
      if (exp_ok) exp_idx = (exp_idx == 99) ? 0 : exp_idx + 1;
      check("save_done",  32'(got_done), 32'(exp_ok));
      check("save_error", 32'(got_err), 32'(!exp_ok));
      check("busy_cycles", 32'(busy_cycles), 32'(exp_busy));
      check("write_issued", 32'(write_seen != 0), 32'(oe == 0));
      check("buf_writes", 32'(wr_count), 32'd33);
      check("buf_addr_seq", 32'(addr_err), 32'd0);
      check("buf_contents", 32'(mism), 32'd0);
      check("cmd_fields", 32'(proto_err), 32'd0);
      check("save_index", 32'(save_index), 32'(exp_idx));
      check("busy_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      int idle_busy;
      rst = 1'b1; save_req = 1'b0;
      #1;
      check("rst_ctrl", {26'd0, busy, save_done, save_error, buf_wr, openfile, write_cmd}, 32'd0);
      check("rst_index", 32'(save_index), 32'd0);
      check("rst_bus", {8'd0, path_addr, buf_addr, buf_data}, 32'd0);
      check("rst_id", 32'(ds_id), 32'd0);
      check("rst_len", ds_len, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // nominal save with 3-cycle bridge latency
      do_save(3, 3, 0, 0);
      check("first_index", 32'(save_index), 32'd1);
      // ack and done together on both commands
      do_save(0, 0, 0, 0);
      // openfile error: write never issued, index unchanged
      do_save(3, 3, 3'd2, 0);
      // write error
      do_save(1, 2, 0, 3'd5);

      // bridge silent: openfile held TMO cycles, then abort; second request ignored
      cfg_never_ack = 1; cfg_ack_dly = 0; cfg_done_dly = 0;
      run_save(5);
      cfg_never_ack = 0;
      idle_busy = 0;
      for (int i = 0; i < 10; i++) begin
         if (busy) idle_busy++;
         @(negedge clk);
      end
      check("tmo_error", 32'(got_err), 32'd1);
      check("tmo_done", 32'(got_done), 32'd0);
      check("tmo_open_cycles", 32'(open_cyc), 32'(TMO));
      check("tmo_busy_cycles", 32'(busy_cycles), 32'(34 + TMO));
      check("tmo_no_write", 32'(write_seen), 32'd0);
      check("tmo_one_start", 32'(rises), 32'd1);
      check("tmo_no_restart", 32'(idle_busy), 32'd0);
      check("tmo_index", 32'(save_index), 32'(exp_idx));

      // randomized bridge latencies and error codes
      for (int n = 0; n < 20; n++) begin
         int unsigned a = $urandom_range(0, 4);
         int unsigned d = $urandom_range(0, 4);
         logic [2:0] oe = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         logic [2:0] we = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         do_save(a, d, oe, we);
      end

      // run up to index 99, save it, then expect wrap to 0
      for (int n = 0; n < 120 && exp_idx != 99; n++) do_save(0, 0, 0, 0);
      check("reached_99", 32'(save_index), 32'd99);
      do_save(0, 1, 0, 0);
      check("digits_99", {16'd0, buf_mem[26], buf_mem[27]}, {16'd0, 8'h39, 8'h39});
      check("wrap_index", 32'(save_index), 32'd0);
      do_save(2, 0, 0, 0);

      // async reset in the middle of COPY
      cfg_ack_dly = 0; cfg_done_dly = 0;
      save_req = 1'b1;
      @(negedge clk);
      save_req = 1'b0;
      for (int i = 0; i < 50 && path_addr != 8'd10; i++) @(negedge clk);
      check("reach_addr10", 32'(path_addr), 32'd10);
      rst = 1'b1;
      #1;
      check("mid_rst_ctrl", {26'd0, busy, save_done, save_error, buf_wr, openfile, write_cmd}, 32'd0);
      check("mid_rst_index", 32'(save_index), 32'd0);
      check("mid_rst_bus", {8'd0, path_addr, buf_addr, buf_data}, 32'd0);
      check("mid_rst_id", 32'(ds_id), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      exp_idx = 0;
      do_save(3, 3, 0, 0);
      check("restart_addr", 32'(fp_addr), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
